// File: rtl/delay_tap_pkg.sv
// Shared types and constants for the delay-line tap controller.
// Optional calibration states are present only when DELAY_TAP_CTRL_CAL_EN is defined.
package delay_tap_pkg;

   localparam int NMBR_CASCADES_DEF = 8;
   localparam int CAL_SAMPLES       = 16;
   localparam int CAL_THRESH        = 8;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_STEP,
      ST_SETTLE,
      ST_DONE
`ifdef DELAY_TAP_CTRL_CAL_EN
      , ST_CAL_SAMPLE
`endif
   } state_e;

   // Counter width able to hold the largest window loaded into the timer.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/tap_settle_timer.sv
// Loadable down-counter shared by the INIT hold, the SETTLE gap and the
// calibration sample window. expire is high while the count sits at zero.
module tap_settle_timer #(
   parameter int               CNT_W   = 4,
   parameter logic [CNT_W-1:0] RST_VAL = '0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             expire
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: load wins, otherwise count down and park at zero.
   always_comb begin
      // NOTE: give every always_comb output a default first so no path infers a latch.
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Count register; reset preloads the INIT hold length.
   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (RST) begin
         cnt_q <= RST_VAL;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = (cnt_q == '0);

endmodule

// File: rtl/delay_tap_ctrl.sv
// Command-side controller for a cascaded variable delay line. Accepts a target
// tap over valid/ready and walks the line one tap per CE pulse with a settle
// gap between steps. All outputs are registered from the next-state decode.
// Optional sweep calibration: define DELAY_TAP_CTRL_CAL_EN.
module delay_tap_ctrl
   import delay_tap_pkg::*;
#(
   parameter int NMBR_CASCADES = NMBR_CASCADES_DEF,
   parameter int TAP_W         = $clog2(NMBR_CASCADES),
   parameter int SETTLE_CYC    = 2,
   parameter int INIT_RST_CYC  = 2
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [TAP_W-1:0] tgt_tap,
   input  logic             tgt_valid,
   output logic             tgt_ready,
   output logic [TAP_W-1:0] cur_tap,
   output logic             busy,
   output logic             done,
   output logic             err_range,
   output logic             DLY_CE,
   output logic             DLY_INC,
   output logic             DLY_RST,
   output logic             DLY_EN_VTC
`ifdef DELAY_TAP_CTRL_CAL_EN
   ,
   input  logic             cal_start,
   input  logic             dly_dataout,
   output logic [TAP_W-1:0] edge_tap,
   output logic             cal_fail
`endif
);

   localparam int               CNT_W     = cnt_width(SETTLE_CYC, INIT_RST_CYC, CAL_SAMPLES);
   localparam logic [TAP_W-1:0] TAP_MAX   = TAP_W'(NMBR_CASCADES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);

   state_e           state_q, state_d;
   logic [TAP_W-1:0] cur_tap_q, cur_tap_d;
   logic [TAP_W-1:0] tgt_q, tgt_d;
   logic             err_range_q, err_range_d;
   logic             tgt_ready_q, tgt_ready_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             dly_ce_q, dly_ce_d;
   logic             dly_inc_q, dly_inc_d;
   logic             dly_rst_q, dly_rst_d;
   logic             dly_en_vtc_q, dly_en_vtc_d;

   logic             tmr_load;
   logic [CNT_W-1:0] tmr_val;
   logic             tmr_expire;

`ifdef DELAY_TAP_CTRL_CAL_EN
   localparam int               ONES_W    = $clog2(CAL_SAMPLES + 1);
   localparam logic [CNT_W-1:0] SAMPLE_LD = CNT_W'(CAL_SAMPLES - 1);

   logic              cal_active_q, cal_active_d;
   logic              prev_below_q, prev_below_d;
   logic [ONES_W-1:0] ones_q, ones_d;
   logic [ONES_W-1:0] ones_total;
   logic [TAP_W-1:0]  edge_tap_q, edge_tap_d;
   logic              cal_fail_q, cal_fail_d;
`endif

   tap_settle_timer #(
      .CNT_W   (CNT_W),
      .RST_VAL (CNT_W'(INIT_RST_CYC))
   ) u_timer (
      .CLK      (CLK),
      .RST      (RST),
      .load     (tmr_load),
      .load_val (tmr_val),
      .expire   (tmr_expire)
   );

   // Next-state, tap tracking and registered-output decode.
   always_comb begin
      state_d     = state_q;
      cur_tap_d   = cur_tap_q;
      tgt_d       = tgt_q;
      err_range_d = err_range_q;
      tmr_load    = 1'b0;
      tmr_val     = '0;
`ifdef DELAY_TAP_CTRL_CAL_EN
      cal_active_d = cal_active_q;
      prev_below_d = prev_below_q;
      ones_d       = ones_q;
      ones_total   = ones_q + ONES_W'(dly_dataout);
      edge_tap_d   = edge_tap_q;
      cal_fail_d   = cal_fail_q;
`endif

      case (state_q)
         ST_INIT: begin
            // The line reset selects tap 0, so the tracked tap follows it.
            cur_tap_d = '0;
            if (tmr_expire) state_d = ST_IDLE;
         end
         ST_IDLE: begin
`ifdef DELAY_TAP_CTRL_CAL_EN
            if (cal_start) begin
               cal_active_d = 1'b1;
               cal_fail_d   = 1'b0;
               prev_below_d = 1'b0;
               tgt_d        = '0;
               if (cur_tap_q == '0) begin
                  state_d  = ST_CAL_SAMPLE;
                  ones_d   = '0;
                  tmr_load = 1'b1;
                  tmr_val  = SAMPLE_LD;
               end else begin
                  state_d = ST_STEP;
               end
            end else
`endif
            if (tgt_valid) begin
               err_range_d = (tgt_tap > TAP_MAX);
               tgt_d       = err_range_d ? TAP_MAX : tgt_tap;
               state_d     = (tgt_d == cur_tap_q) ? ST_DONE : ST_STEP;
            end
         end
         ST_STEP: begin
            cur_tap_d = (tgt_q > cur_tap_q) ? cur_tap_q + 1'b1 : cur_tap_q - 1'b1;
            state_d   = ST_SETTLE;
            tmr_load  = 1'b1;
            tmr_val   = SETTLE_LD;
         end
         ST_SETTLE: begin
            if (tmr_expire) begin
               if (cur_tap_q != tgt_q) begin
                  state_d = ST_STEP;
`ifdef DELAY_TAP_CTRL_CAL_EN
               end else if (cal_active_q) begin
                  state_d  = ST_CAL_SAMPLE;
                  ones_d   = '0;
                  tmr_load = 1'b1;
                  tmr_val  = SAMPLE_LD;
`endif
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
`ifdef DELAY_TAP_CTRL_CAL_EN
         ST_CAL_SAMPLE: begin
            ones_d = ones_total;
            if (tmr_expire) begin
               if (ones_total >= ONES_W'(CAL_THRESH) && prev_below_q) begin
                  // First low-to-high crossing: the line already sits on it.
                  edge_tap_d   = cur_tap_q;
                  cal_active_d = 1'b0;
                  state_d      = ST_DONE;
               end else if (cur_tap_q == TAP_MAX) begin
                  // Swept the whole line without a crossing: fall back to tap 0.
                  cal_fail_d   = 1'b1;
                  cal_active_d = 1'b0;
                  tgt_d        = '0;
                  state_d      = (cur_tap_q == '0) ? ST_DONE : ST_STEP;
               end else begin
                  prev_below_d = (ones_total < ONES_W'(CAL_THRESH));
                  tgt_d        = cur_tap_q + 1'b1;
                  state_d      = ST_STEP;
               end
            end
         end
`endif
         default: begin
            state_d = ST_INIT;
         end
      endcase

      // Outputs follow the state being entered so they are valid from its first cycle.
      tgt_ready_d  = (state_d == ST_IDLE);
      dly_en_vtc_d = (state_d == ST_IDLE);
      busy_d       = (state_d != ST_IDLE);
      done_d       = (state_d == ST_DONE);
      dly_ce_d     = (state_d == ST_STEP);
      dly_rst_d    = (state_d == ST_INIT);
      dly_inc_d    = (state_d == ST_STEP) ? (tgt_d > cur_tap_d) : dly_inc_q;
   end

   // State and output registers; reset aborts any step and reissues DLY_RST.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= ST_INIT;
         cur_tap_q    <= '0;
         tgt_q        <= '0;
         err_range_q  <= 1'b0;
         tgt_ready_q  <= 1'b0;
         busy_q       <= 1'b1;
         done_q       <= 1'b0;
         dly_ce_q     <= 1'b0;
         dly_inc_q    <= 1'b0;
         dly_rst_q    <= 1'b1;
         dly_en_vtc_q <= 1'b0;
`ifdef DELAY_TAP_CTRL_CAL_EN
         cal_active_q <= 1'b0;
         prev_below_q <= 1'b0;
         ones_q       <= '0;
         edge_tap_q   <= '0;
         cal_fail_q   <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cur_tap_q    <= cur_tap_d;
         tgt_q        <= tgt_d;
         err_range_q  <= err_range_d;
         tgt_ready_q  <= tgt_ready_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         dly_ce_q     <= dly_ce_d;
         dly_inc_q    <= dly_inc_d;
         dly_rst_q    <= dly_rst_d;
         dly_en_vtc_q <= dly_en_vtc_d;
`ifdef DELAY_TAP_CTRL_CAL_EN
         cal_active_q <= cal_active_d;
         prev_below_q <= prev_below_d;
         ones_q       <= ones_d;
         edge_tap_q   <= edge_tap_d;
         cal_fail_q   <= cal_fail_d;
`endif
      end
   end

   assign tgt_ready  = tgt_ready_q;
   assign cur_tap    = cur_tap_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err_range  = err_range_q;
   assign DLY_CE     = dly_ce_q;
   assign DLY_INC    = dly_inc_q;
   assign DLY_RST    = dly_rst_q;
   assign DLY_EN_VTC = dly_en_vtc_q;
`ifdef DELAY_TAP_CTRL_CAL_EN
   assign edge_tap   = edge_tap_q;
   assign cal_fail   = cal_fail_q;
`endif

endmodule

// File: tb/tb_delay_tap_ctrl.sv
// Directed bench for delay_tap_ctrl: reset hold, increment, decrement, null,
// out-of-range clamp, reset mid-move and (with DELAY_TAP_CTRL_CAL_EN) calibration.
module tb_delay_tap_ctrl;

   logic       CLK = 1'b0;
   logic       RST;
   logic [3:0] tgt_tap;
   logic       tgt_valid;
   logic       tgt_ready;
   logic [3:0] cur_tap;
   logic       busy, done, err_range;
   logic       DLY_CE, DLY_INC, DLY_RST, DLY_EN_VTC;
`ifdef DELAY_TAP_CTRL_CAL_EN
   logic       cal_start;
   logic       dly_dataout;
   logic [3:0] edge_tap;
   logic       cal_fail;
   logic       cal_zero;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int ce_tot = 0;
   int inc_tot = 0;
   int done_tot = 0;
   int done_cyc = -1;
   int last_ce_cyc = -100;
   int gap_bad = 0;
   int line_tap = 0;

   delay_tap_ctrl #(
      .NMBR_CASCADES (8),
      .TAP_W         (4),
      .SETTLE_CYC    (2),
      .INIT_RST_CYC  (2)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .tgt_tap    (tgt_tap),
      .tgt_valid  (tgt_valid),
      .tgt_ready  (tgt_ready),
      .cur_tap    (cur_tap),
      .busy       (busy),
      .done       (done),
      .err_range  (err_range),
      .DLY_CE     (DLY_CE),
      .DLY_INC    (DLY_INC),
      .DLY_RST    (DLY_RST),
      .DLY_EN_VTC (DLY_EN_VTC)
`ifdef DELAY_TAP_CTRL_CAL_EN
      ,
      .cal_start   (cal_start),
      .dly_dataout (dly_dataout),
      .edge_tap    (edge_tap),
      .cal_fail    (cal_fail)
`endif
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // Independent model of the delay line driven only by its pins.
   always @(posedge CLK) begin
      if (DLY_RST)     line_tap <= 0;
      else if (DLY_CE) line_tap <= DLY_INC ? line_tap + 1 : line_tap - 1;
   end

`ifdef DELAY_TAP_CTRL_CAL_EN
   assign dly_dataout = cal_zero ? 1'b0 : (line_tap >= 3);
`endif

   // Pin monitor: CE pulses, their direction and spacing, done pulses.
   always @(negedge CLK) begin
      if (DLY_CE) begin
         ce_tot = ce_tot + 1;
         if (DLY_INC) inc_tot = inc_tot + 1;
         if (cyc - last_ce_cyc < 3) gap_bad = gap_bad + 1;
         last_ce_cyc = cyc;
      end
      if (done) begin
         done_tot = done_tot + 1;
         done_cyc = cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step_cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_done(input string tag, input int base, input int budget);
      int n;
      n = 0;
      while (done_tot == base && n < budget) begin
         @(posedge CLK);
         n++;
      end
      #1;
      chk({tag, "_timeout"}, 32'(done_tot != base), 1);
   endtask

   // One request; expected CE count, direction, done latency and final tap given by the caller.
   task automatic do_move(input string tag, input logic [3:0] tap, input int steps,
                          input bit up, input logic [3:0] fin);
      int t, b_ce, b_inc, b_done;
      b_ce   = ce_tot;
      b_inc  = inc_tot;
      b_done = done_tot;
      chk({tag, "_ready_pre"}, 32'(tgt_ready), 1);
      t         = cyc;
      tgt_tap   = tap;
      tgt_valid = 1'b1;
      step_cyc();
      tgt_valid = 1'b0;
      chk({tag, "_busy"}, 32'(busy), 1);
      chk({tag, "_ready_busy"}, 32'(tgt_ready), 0);
      wait_done(tag, b_done, 300);
      chk({tag, "_done_cyc"}, done_cyc, t + 1 + 3 * steps);
      chk({tag, "_ce_cnt"}, ce_tot - b_ce, steps);
      chk({tag, "_inc_cnt"}, inc_tot - b_inc, up ? steps : 0);
      if (steps > 0) chk({tag, "_last_ce"}, last_ce_cyc, t + 1 + 3 * (steps - 1));
      chk({tag, "_cur_tap"}, 32'(cur_tap), 32'(fin));
      chk({tag, "_line_tap"}, line_tap, 32'(fin));
      chk({tag, "_ready_post"}, 32'(tgt_ready), 1);
      chk({tag, "_vtc_post"}, 32'(DLY_EN_VTC), 1);
      step_cyc();
      chk({tag, "_done_pulses"}, done_tot - b_done, 1);
   endtask

   initial begin
      int t, b_ce, b_done;
      RST       = 1'b1;
      tgt_tap   = '0;
      tgt_valid = 1'b0;
`ifdef DELAY_TAP_CTRL_CAL_EN
      cal_start = 1'b0;
      cal_zero  = 1'b0;
`endif

      // Reset values while RST is held.
      repeat (2) step_cyc();
      chk("rst_dly_rst", 32'(DLY_RST), 1);
      chk("rst_busy", 32'(busy), 1);
      chk("rst_ready", 32'(tgt_ready), 0);
      chk("rst_vtc", 32'(DLY_EN_VTC), 0);
      chk("rst_cur_tap", 32'(cur_tap), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_ce", 32'(DLY_CE), 0);
      chk("rst_inc", 32'(DLY_INC), 0);
      chk("rst_err", 32'(err_range), 0);
      RST = 1'b0;

      // DLY_RST held two cycles after release, then IDLE.
      step_cyc();
      chk("init_hold1", 32'(DLY_RST), 1);
      chk("init_ready1", 32'(tgt_ready), 0);
      step_cyc();
      chk("init_hold2", 32'(DLY_RST), 1);
      step_cyc();
      chk("idle_dly_rst", 32'(DLY_RST), 0);
      chk("idle_ready", 32'(tgt_ready), 1);
      chk("idle_vtc", 32'(DLY_EN_VTC), 1);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_cur_tap", 32'(cur_tap), 0);

      do_move("inc_0to5", 4'd5, 5, 1'b1, 4'd5);
      chk("inc_hold", 32'(DLY_INC), 1);
      do_move("dec_5to2", 4'd2, 3, 1'b0, 4'd2);
      chk("dec_hold", 32'(DLY_INC), 0);
      do_move("null_2", 4'd2, 0, 1'b0, 4'd2);
      chk("null_err", 32'(err_range), 0);
      do_move("range_9", 4'd9, 5, 1'b1, 4'd7);
      chk("range_err", 32'(err_range), 1);
      do_move("inrange_7", 4'd7, 0, 1'b0, 4'd7);
      chk("inrange_err_clr", 32'(err_range), 0);
      do_move("home_7to0", 4'd0, 7, 1'b0, 4'd0);

      // Reset during the second settle of a 0->6 move.
      b_ce      = ce_tot;
      b_done    = done_tot;
      t         = cyc;
      tgt_tap   = 4'd6;
      tgt_valid = 1'b1;
      step_cyc();
      tgt_valid = 1'b0;
      repeat (4) step_cyc();
      chk("mid_cur_tap", 32'(cur_tap), 2);
      chk("mid_cyc", cyc, t + 5);
      RST = 1'b1;
      step_cyc();
      RST = 1'b0;
      chk("mid_rst_ce", 32'(DLY_CE), 0);
      chk("mid_rst_dly_rst", 32'(DLY_RST), 1);
      chk("mid_rst_cur_tap", 32'(cur_tap), 0);
      chk("mid_rst_busy", 32'(busy), 1);
      step_cyc();
      chk("mid_hold1", 32'(DLY_RST), 1);
      step_cyc();
      chk("mid_hold2", 32'(DLY_RST), 1);
      step_cyc();
      chk("mid_idle_dly_rst", 32'(DLY_RST), 0);
      chk("mid_idle_ready", 32'(tgt_ready), 1);
      repeat (6) step_cyc();
      chk("mid_ce_cnt", ce_tot - b_ce, 2);
      chk("mid_no_done", done_tot - b_done, 0);
      chk("mid_line_tap", line_tap, 0);

`ifdef DELAY_TAP_CTRL_CAL_EN
      // Edge at tap 3: line output low below tap 3, high from tap 3.
      do_move("cal_pre", 4'd4, 4, 1'b1, 4'd4);
      b_done    = done_tot;
      cal_zero  = 1'b0;
      cal_start = 1'b1;
      step_cyc();
      cal_start = 1'b0;
      wait_done("cal_edge", b_done, 2000);
      chk("cal_edge_tap", 32'(edge_tap), 3);
      chk("cal_edge_cur", 32'(cur_tap), 3);
      chk("cal_edge_fail", 32'(cal_fail), 0);
      step_cyc();

      // Constant-low line: no crossing, fail and return to tap 0.
      b_done    = done_tot;
      cal_zero  = 1'b1;
      cal_start = 1'b1;
      step_cyc();
      cal_start = 1'b0;
      wait_done("cal_zero", b_done, 3000);
      chk("cal_zero_fail", 32'(cal_fail), 1);
      chk("cal_zero_cur", 32'(cur_tap), 0);
      chk("cal_zero_line", line_tap, 0);
      step_cyc();
`endif

      chk("ce_spacing", gap_bad, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/delay_tap_ctrl.md
Name: delay_tap_ctrl

Overview:
- Command-side controller for the cascaded variable delay line (IDELAYE3-style wrapper, VARIABLE mode).
- Accepts a target tap index over a valid/ready handshake and drives the line's CE/INC/RST/EN_VTC pins one tap step at a time, with a settle gap between steps.
- Tracks the current tap and reports completion. Sits between the calibration/software register layer and each delay-line instance.

Parameters:
- NMBR_CASCADES, 8, number of delay taps; legal tap indices are 0..NMBR_CASCADES-1.
- TAP_W, $clog2(NMBR_CASCADES), width of tap index buses.
- SETTLE_CYC, 2, idle cycles after each CE pulse before the next step; must be 1..15.
- INIT_RST_CYC, 2, cycles DLY_RST is held after reset release.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous reset, active-high.
- tgt_tap  in  TAP_W  requested tap index.
- tgt_valid  in  1  request valid.
- tgt_ready  out  1  controller can accept a request.
- cur_tap  out  TAP_W  tap currently applied in the delay line.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when the target tap is reached.
- err_range  out  1  sticky; set when tgt_tap > NMBR_CASCADES-1; cleared by RST or by an accepted in-range request.
- DLY_CE  out  1  to delay line CE.
- DLY_INC  out  1  to delay line INC.
- DLY_RST  out  1  to delay line RST.
- DLY_EN_VTC  out  1  to delay line EN_VTC.

Behaviour:
- Reset values: tgt_ready=0, cur_tap=0, busy=1, done=0, err_range=0, DLY_CE=0, DLY_INC=0, DLY_RST=1, DLY_EN_VTC=0. FSM enters INIT.
- States: INIT, IDLE, STEP, SETTLE, DONE.
- INIT:
  - DLY_RST=1 for INIT_RST_CYC cycles counted from reset release, then IDLE.
  - cur_tap=0, because delay-line reset selects tap 0 (one-hot 00000001 in BALANCED mode).
- IDLE:
  - tgt_ready=1, DLY_EN_VTC=1, busy=0.
  - On tgt_valid&&tgt_ready: latch tgt = min(tgt_tap, NMBR_CASCADES-1). Update err_range.
  - If tgt==cur_tap, go to DONE; otherwise go to STEP.
- STEP (1 cycle):
  - DLY_CE=1; DLY_INC=(tgt>cur_tap).
  - At the clock edge leaving STEP, cur_tap moves ±1 toward tgt.
  - Go to SETTLE.
- SETTLE:
  - SETTLE_CYC cycles with DLY_CE=0.
  - Then STEP if cur_tap!=tgt, else DONE.
- DONE (1 cycle): done=1, then IDLE.
- DLY_EN_VTC=0 in every state except IDLE (VTC must be off while stepping). DLY_INC holds its last value outside STEP. tgt_ready=0 outside IDLE.
- Latency: request accepted at cycle t gives done at cycle t+1+|tgt-cur|*(1+SETTLE_CYC).
- cur_tap never leaves 0..NMBR_CASCADES-1: no wrap-around, no CE issued beyond the ends.
- tgt_valid while busy: ignored; the requester holds it until handshake.
- RST mid-operation: any DLY_CE pulse is aborted. Return to INIT; DLY_RST is reissued so the line and cur_tap agree at 0.

Optional Feature:
- Macro: DELAY_TAP_CTRL_CAL_EN.
- With the macro:
  - Extra ports cal_start in 1, dly_dataout in 1, edge_tap out TAP_W, cal_fail out 1.
  - cal_start in IDLE starts a sweep from tap 0 to the top tap.
  - After each settle, sample dly_dataout for 16 cycles and count ones.
  - edge_tap = first tap where the count crosses from <8 to >=8. The controller then steps to edge_tap and pulses done.
  - If no crossing occurs: cal_fail=1, return to tap 0.
  - cal_start has priority over a simultaneous tgt_valid.
- Without the macro: none of these ports or states exist.

Decomposition:
- Package delay_tap_pkg holds:
  - state enum (INIT, IDLE, STEP, SETTLE, DONE, plus CAL_* states under the macro);
  - NMBR_CASCADES default;
  - CAL_SAMPLES=16 and CAL_THRESH=8.
- One sub-module is natural: tap_settle_timer, a loadable down-counter for SETTLE/INIT/sample windows that asserts expire.

Test Plan:
- Reset: RST high 2 cycles then low. DLY_RST stays high for INIT_RST_CYC cycles after release, then tgt_ready=1, DLY_EN_VTC=1, cur_tap=0.
- Increment: from tap 0, request tgt_tap=5. Expect 5 DLY_CE pulses with DLY_INC=1, spaced 3 cycles apart, and done at t+16 with cur_tap=5.
- Decrement: from tap 5, request tgt_tap=2. Expect 3 pulses with DLY_INC=0 and done at t+10 with cur_tap=2.
- Null and range: request cur_tap gives done at t+1 with no CE. Request tgt_tap=9 (with TAP_W=4, NMBR_CASCADES=8) sets err_range=1 and lands on cur_tap=7.
- Reset mid-step: RST asserted during the 2nd SETTLE of a 0→6 move. Expect DLY_CE=0, DLY_RST reissued, cur_tap=0, no done pulse.
- Calibration (DELAY_TAP_CTRL_CAL_EN): dly_dataout modelled as 0 for taps<3 and 1 for taps>=3. Expect edge_tap=3, final cur_tap=3, cal_fail=0. With a constant 0 input: cal_fail=1, cur_tap=0.
